// File: rtl/axi_lite_arb2_if.sv
// axi_lite_arb2_if: AXI4-Lite subset (AW, W, AR/R; no B channel) between one master and one slave
interface axi_lite_arb2_if #(parameter int AW = 32, parameter int DW = 32);
   logic [AW-1:0]   awaddr;
   logic            awvalid, awready;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic            wvalid, wready;
   logic [AW-1:0]   araddr;
   logic            arvalid, arready;
   logic [DW-1:0]   rdata;
   logic            rvalid, rready;
   modport master (output awaddr, awvalid, wdata, wstrb, wvalid, araddr, arvalid, rready,
                   input awready, wready, arready, rdata, rvalid);
   modport slave (input awaddr, awvalid, wdata, wstrb, wvalid, araddr, arvalid, rready,
                  output awready, wready, arready, rdata, rvalid);
endinterface

// File: rtl/axi_lite_arb2.sv
// axi_lite_arb2: two-master to one-slave AXI4-Lite arbiter, independent write and read arbitration
module axi_lite_arb2 #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int FIXED_PRIO = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   axi_lite_arb2_if.slave   m0,
   axi_lite_arb2_if.slave   m1,
   axi_lite_arb2_if.master  s
);
   logic w_lock, w_sel, w_last, r_lock, r_sel, r_last, r_busy, r_owner;
   logic wreq0, wreq1, w_act, w_gnt, w_hs;
   logic r_act, r_gnt, ar_ok, ar_hs, r_hs;
   logic [AW-1:0]   aw_addr, ar_addr;
   logic [DW-1:0]   w_data;
   logic [DW/8-1:0] w_strb;
   assign wreq0 = m0.awvalid & m0.wvalid;
   assign wreq1 = m1.awvalid & m1.wvalid;
   assign w_act = w_lock | wreq0 | wreq1;
   assign w_gnt = w_lock ? w_sel : (wreq0 & wreq1) ? ((FIXED_PRIO != 0) ? 1'b0 : ~w_last) : wreq1;
   assign aw_addr = w_gnt ? m1.awaddr : m0.awaddr;
   assign w_data = w_gnt ? m1.wdata : m0.wdata;
   assign w_strb = w_gnt ? m1.wstrb : m0.wstrb;
   assign s.awaddr = aw_addr;
   assign s.wdata = w_data;
   assign s.wstrb = w_strb;
   assign s.awvalid = w_act & (w_gnt ? m1.awvalid : m0.awvalid);
   assign s.wvalid = w_act & (w_gnt ? m1.wvalid : m0.wvalid);
   assign m0.awready = w_act & ~w_gnt & s.awready;
   assign m1.awready = w_act & w_gnt & s.awready;
   assign m0.wready = w_act & ~w_gnt & s.wready;
   assign m1.wready = w_act & w_gnt & s.wready;
   assign w_hs = s.awvalid & s.awready & s.wvalid & s.wready;
   // A new AR may overlap the completing R so back-to-back reads need no bubble
   assign r_hs = s.rvalid & s.rready;
   assign ar_ok = ~r_busy | r_hs;
   assign r_act = r_lock | m0.arvalid | m1.arvalid;
   assign r_gnt = r_lock ? r_sel : (m0.arvalid & m1.arvalid) ? ((FIXED_PRIO != 0) ? 1'b0 : ~r_last) : m1.arvalid;
   assign ar_addr = r_gnt ? m1.araddr : m0.araddr;
   assign s.araddr = ar_addr;
   assign s.arvalid = r_act & ar_ok & (r_gnt ? m1.arvalid : m0.arvalid);
   assign m0.arready = r_act & ~r_gnt & ar_ok & s.arready;
   assign m1.arready = r_act & r_gnt & ar_ok & s.arready;
   assign ar_hs = s.arvalid & s.arready;
   assign s.rready = r_busy & (r_owner ? m1.rready : m0.rready);
   assign m0.rvalid = s.rvalid & r_busy & ~r_owner;
   assign m1.rvalid = s.rvalid & r_busy & r_owner;
   assign m0.rdata = s.rdata;
   assign m1.rdata = s.rdata;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_lock <= 1'b0;
         w_sel <= 1'b0;
         w_last <= 1'b1;
         r_lock <= 1'b0;
         r_sel <= 1'b0;
         r_last <= 1'b1;
         r_busy <= 1'b0;
         r_owner <= 1'b0;
      end else begin
         if (w_hs) begin
            w_lock <= 1'b0;
            w_last <= w_gnt;
         end else if (w_act) begin
            w_lock <= 1'b1;
            w_sel <= w_gnt;
         end
         if (ar_hs) begin
            r_busy <= 1'b1;
            r_owner <= r_gnt;
            r_last <= r_gnt;
            r_lock <= 1'b0;
         end else begin
            if (r_hs) r_busy <= 1'b0;
            if (r_act) begin
               r_lock <= 1'b1;
               r_sel <= r_gnt;
            end
         end
      end
   end
endmodule

// File: tb/tb_axi_lite_arb2.sv
// tb_axi_lite_arb2: directed checks of write/read arbitration, locking, routing and reset
module tb_axi_lite_arb2;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int failures = 0;
   logic [31:0] exp_rr [4] = '{32'h10, 32'h20, 32'h10, 32'h20};
   always #5 clk = ~clk;
   axi_lite_arb2_if m0 (), m1 (), s (), m0f (), m1f (), sf ();
   axi_lite_arb2 dut (.clk(clk), .rst_n(rst_n), .m0(m0), .m1(m1), .s(s));
   axi_lite_arb2 #(.FIXED_PRIO(1)) dut_fix (.clk(clk), .rst_n(rst_n), .m0(m0f), .m1(m1f), .s(sf));
   assign m0f.awaddr = m0.awaddr, m0f.awvalid = m0.awvalid, m0f.wdata = m0.wdata,
          m0f.wstrb = m0.wstrb, m0f.wvalid = m0.wvalid, m0f.araddr = '0, m0f.arvalid = 1'b0,
          m0f.rready = 1'b0;
   assign m1f.awaddr = m1.awaddr, m1f.awvalid = m1.awvalid, m1f.wdata = m1.wdata,
          m1f.wstrb = m1.wstrb, m1f.wvalid = m1.wvalid, m1f.araddr = '0, m1f.arvalid = 1'b0,
          m1f.rready = 1'b0;
   assign sf.awready = s.awready, sf.wready = s.wready, sf.arready = 1'b0,
          sf.rdata = '0, sf.rvalid = 1'b0;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #2;
   endtask
   task automatic idle;
      {m0.awvalid, m0.wvalid, m0.arvalid, m0.rready} = '0;
      {m1.awvalid, m1.wvalid, m1.arvalid, m1.rready} = '0;
      {m0.awaddr, m0.wdata, m0.wstrb, m0.araddr} = '0;
      {m1.awaddr, m1.wdata, m1.wstrb, m1.araddr} = '0;
      {s.awready, s.wready, s.arready, s.rvalid, s.rdata} = '0;
   endtask
   task automatic do_reset;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
   endtask
   initial begin
      idle;
      {s.awready, s.wready, s.arready, s.rvalid} = 4'hF;
      #3;
      chk("rst_s_awvalid", s.awvalid, 0);
      chk("rst_s_arvalid", s.arvalid, 0);
      chk("rst_m0_awready", m0.awready, 0);
      chk("rst_m1_rvalid", m1.rvalid, 0);
      chk("rst_s_rready", s.rready, 0);
      tick;
      rst_n = 1'b1;
      #1;
      chk("post_rst_m0_rvalid", m0.rvalid, 0);
      chk("post_rst_m1_arready", m1.arready, 0);
      idle;
      // single master write, slave ready at once
      m0.awaddr = 32'h100;
      m0.wdata = 32'hA5A5_0001;
      m0.wstrb = 4'hF;
      {m0.awvalid, m0.wvalid, s.awready, s.wready} = 4'hF;
      #1;
      chk("wr_s_awaddr", s.awaddr, 32'h100);
      chk("wr_s_wdata", s.wdata, 32'hA5A5_0001);
      chk("wr_s_wstrb", s.wstrb, 4'hF);
      chk("wr_m0_awready", m0.awready, 1);
      chk("wr_m0_wready", m0.wready, 1);
      chk("wr_m1_awready", m1.awready, 0);
      chk("wr_m1_wready", m1.wready, 0);
      tick;
      idle;
      // contention: round-robin alternates, fixed priority keeps m0
      do_reset;
      m0.awaddr = 32'h10;
      m1.awaddr = 32'h20;
      {m0.awvalid, m0.wvalid, m1.awvalid, m1.wvalid, s.awready, s.wready} = 6'h3F;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_s_awaddr", s.awaddr, exp_rr[i]);
         chk("fix_s_awaddr", sf.awaddr, 32'h10);
         chk("fix_m1_awready", m1f.awready, 0);
         tick;
      end
      idle;
      // grant lock: m1 held by awready=0 while m0 joins
      m1.awaddr = 32'h20;
      m0.awaddr = 32'h10;
      {m1.awvalid, m1.wvalid, s.wready} = 3'h7;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) {m0.awvalid, m0.wvalid} = 2'h3;
         #1;
         chk("lock_s_awaddr", s.awaddr, 32'h20);
         chk("lock_m0_wready", m0.wready, 0);
         tick;
      end
      s.awready = 1'b1;
      #1;
      chk("lock_m1_awready", m1.awready, 1);
      chk("lock_m0_awready", m0.awready, 0);
      tick;
      {m1.awvalid, m1.wvalid} = 2'b00;
      #1;
      chk("lock_next_awaddr", s.awaddr, 32'h10);
      chk("lock_next_m0_awready", m0.awready, 1);
      tick;
      idle;
      // read routing to m1, m0 blocked until the R handshake
      m1.araddr = 32'h204;
      {m1.arvalid, m1.rready, s.arready} = 3'h7;
      #1;
      chk("rd_s_araddr", s.araddr, 32'h204);
      chk("rd_m1_arready", m1.arready, 1);
      tick;
      m1.arvalid = 1'b0;
      m0.araddr = 32'h300;
      m0.arvalid = 1'b1;
      #1;
      chk("rd_m0_arready_busy", m0.arready, 0);
      chk("rd_s_arvalid_busy", s.arvalid, 0);
      tick;
      s.rvalid = 1'b1;
      s.rdata = 32'hDEAD_BEEF;
      #1;
      chk("rd_m1_rvalid", m1.rvalid, 1);
      chk("rd_m1_rdata", m1.rdata, 32'hDEAD_BEEF);
      chk("rd_m0_rvalid", m0.rvalid, 0);
      chk("rd_m0_arready_on_r", m0.arready, 1);
      tick;
      // back-to-back: m0 owns R, m1 AR waits on m0_rready
      m0.arvalid = 1'b0;
      m1.araddr = 32'h208;
      m1.arvalid = 1'b1;
      s.rdata = 32'h1111_2222;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("b2b_s_rready", s.rready, 0);
         chk("b2b_m1_arready", m1.arready, 0);
         chk("b2b_m0_rvalid", m0.rvalid, 1);
         tick;
      end
      m0.rready = 1'b1;
      #1;
      chk("b2b_s_rready_go", s.rready, 1);
      chk("b2b_m1_arready_go", m1.arready, 1);
      chk("b2b_s_araddr", s.araddr, 32'h208);
      tick;
      m1.arvalid = 1'b0;
      s.rdata = 32'h3333_4444;
      #1;
      chk("b2b_next_m1_rvalid", m1.rvalid, 1);
      chk("b2b_next_m0_rvalid", m0.rvalid, 0);
      // reset while a read is outstanding
      rst_n = 1'b0;
      #1;
      chk("rstrd_m1_rvalid", m1.rvalid, 0);
      chk("rstrd_s_rready", s.rready, 0);
      tick;
      rst_n = 1'b1;
      #1;
      chk("rstrd_post_m1_rvalid", m1.rvalid, 0);
      s.rvalid = 1'b0;
      m0.araddr = 32'h400;
      m1.araddr = 32'h500;
      {m0.arvalid, m1.arvalid} = 2'b11;
      #1;
      chk("rstrd_s_araddr", s.araddr, 32'h400);
      chk("rstrd_m0_arready", m0.arready, 1);
      chk("rstrd_m1_arready", m1.arready, 0);
      tick;
      idle;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/axi_lite_arb2.md
Name: axi_lite_arb2

Overview:
- Two-master to one-slave AXI4-Lite arbiter in front of the system peripheral bus (UART/SPI/GPIO slave).
- Master 0 is the core data port. Master 1 is a secondary requester (debug module or DMA).
- Uses the same AXI4-Lite subset as the peripheral slave: AW, W and AR/R channels, with no B channel.
- Write and read paths are arbitrated independently. At most one read is outstanding, and R is routed to the master that issued the AR.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- FIXED_PRIO, 0: 0 = round-robin, 1 = master 0 always wins ties.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- mN_awaddr  in  AW  write address, N = 0, 1
- mN_awvalid  in  1  write address valid
- mN_awready  out  1  write address ready
- mN_wdata  in  DW  write data
- mN_wstrb  in  DW/8  byte strobes
- mN_wvalid  in  1  write data valid
- mN_wready  out  1  write data ready
- mN_araddr  in  AW  read address
- mN_arvalid  in  1  read address valid
- mN_arready  out  1  read address ready
- mN_rdata  out  DW  read data
- mN_rvalid  out  1  read data valid
- mN_rready  in  1  read data ready
- s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_araddr, s_arvalid, s_rready: out; widths as the master ports; forwarded to the slave.
- s_awready, s_wready, s_arready, s_rdata, s_rvalid: in; widths as the master ports; from the slave.

Behaviour:
- Reset: rst_n, asynchronous, active-low; clock clk.
  - Cleared state: w_lock=0, r_busy=0, w_last=1, r_last=1 (master 0 wins first).
  - All valid/ready outputs are 0 during and after reset until a request arrives.
  - Data outputs are don't-care but must not be X-sensitive.
- Write request: wreq_N = mN_awvalid & mN_wvalid. A master presenting only one of the two is not requesting.
- Write grant, unlocked (w_lock=0):
  - One request: that master wins.
  - Both requesting: the master other than w_last wins (round-robin), or master 0 wins if FIXED_PRIO=1.
  - The decision is combinational, so there are zero added cycles.
- Write forwarding: the granted master drives s_aw*/s_w* combinationally.
  - s_awvalid = granted mN_awvalid; s_wvalid = granted mN_wvalid.
  - mN_awready = s_awready, mN_wready = s_wready, for the granted master only.
  - The non-granted master sees ready = 0.
- Write completion: write handshake = s_awvalid & s_awready & s_wvalid & s_wready.
  - On a handshake, w_last <= granted index.
  - If granted but no handshake this cycle, set w_lock=1 and w_sel = granted index.
  - While locked, the grant is frozen to w_sel until its handshake, then w_lock clears.
  - A grant never switches while its valids are pending.
- Read grant:
  - AR may be forwarded only when r_busy=0, or when the outstanding R completes this cycle (s_rvalid & s_rready).
  - Master selection is the same rule as writes, using r_last, with its own r_lock/r_sel.
  - s_arvalid = granted mN_arvalid & ar_allowed.
  - mN_arready = s_arready & ar_allowed, for the granted master only.
- Read handshake (s_arvalid & s_arready): r_busy <= 1, r_owner <= granted, r_last <= granted, r_lock <= 0.
- Read response:
  - s_rready = mX_rready of r_owner when r_busy, else 0.
  - mX_rvalid = s_rvalid & r_busy & (r_owner == X); mX_rdata = s_rdata for both masters.
  - On R handshake with no new AR in the same cycle, r_busy <= 0.
  - On R handshake with an AR handshake in the same cycle, r_busy stays 1 and r_owner takes the new index. This supports back-to-back reads with no bubble.
- Simultaneous events: a write and a read in the same cycle, from the same or different masters, proceed independently.
- Reset mid-transaction: all state is dropped immediately. Any in-flight R from the slave after reset is not forwarded (r_busy=0).
- Implementation target: about 200 lines of RTL.

Test Plan:
- Single master, m0 write: awaddr=0x100, wdata=0xA5A5_0001, wstrb=0xF, slave ready immediately -> s_awaddr=0x100 in the same cycle, m0_awready=m0_wready=1, m1 readys=0.
- Contention, round-robin: both masters issue a write every cycle for 4 cycles, slave always ready -> grants alternate m0, m1, m0, m1. With FIXED_PRIO=1 -> m0 on all 4 cycles.
- Grant lock: m1 is granted while s_awready is held 0 for 3 cycles and m0 starts requesting meanwhile -> s_awaddr stays m1's address for all 3 cycles, m1 completes, m0 is granted on the next cycle.
- Read routing: m1 reads 0x204 and the slave returns 0xDEAD_BEEF one cycle later -> only m1_rvalid=1 with data 0xDEAD_BEEF. m0_arvalid presented meanwhile gets m0_arready=0 until that R handshake.
- Back-to-back reads: m0 then m1 AR with the R of m0 and the AR of m1 in the same cycle -> no idle cycle, and the next R goes to m1. Hold m0_rready=0 for 2 cycles -> s_rready=0 and m1_arready=0 throughout.
- Reset mid-read: assert rst_n=0 while r_busy=1, release -> all mN_rvalid=0, next AR accepted with m0 winning first.
